// File: rtl/cache_mem_arbiter_if.sv
// One cache-style memory request port: request fields flow master->slave, read beats and write done flow back.
// Instanced once per cache and once for the shared memory port.
interface cache_mem_arbiter_if #(
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 32
);
  logic [BUS_WIDTH-1:0]    addr;
  logic                    ce;
  logic                    we;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wmask;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    rdata_valid;
  logic                    write_respone;

  modport master (
    output addr, ce, we, wdata, wmask,
    input  rdata, rdata_valid, write_respone
  );

  modport slave (
    input  addr, ce, we, wdata, wmask,
    output rdata, rdata_valid, write_respone
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Purpose: merges ICache and DCache memory ports onto one bus, whole-transaction round-robin (ARB_DCACHE_PRIORITY_EN: DCache fixed priority).
// Latency: ce sampled at edge N drives m_ce in cycle N+1; request fields and responses pass combinationally while granted.
// Backpressure: a requester holds ce until its refill/write completes; the loser waits, grants are never preempted.
module cache_mem_arbiter #(
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  cache_mem_arbiter_if.slave   i_mem,
  cache_mem_arbiter_if.slave   d_mem,
  cache_mem_arbiter_if.master  m,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [CNT_W-1:0]        beat_cnt;
  logic [CNT_W-1:0]        beat_cnt_nxt;
  logic                    prefer_d;

  logic [BUS_WIDTH-1:0]    addr_mux;
  logic                    we_mux;
  logic [DATA_WIDTH-1:0]   wdata_mux;
  logic [DATA_WIDTH/8-1:0] wmask_mux;
  logic                    grant_vld;
  logic                    rd_beat;
  logic                    wr_resp;

`ifdef ARB_DCACHE_PRIORITY_EN
  assign prefer_d = 1'b1;
`else
  // last_grant_d: 0 = ICache had the last grant, so DCache wins the next tie.
  logic last_grant_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_d <= 1'b0;
    end else if (state == IDLE && state_nxt != IDLE) begin
      last_grant_d <= (state_nxt == GRANT_D);
    end
  end

  assign prefer_d = ~last_grant_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (d_mem.ce && (!i_mem.ce || prefer_d)) begin
          state_nxt = GRANT_D;
        end else if (i_mem.ce) begin
          state_nxt = GRANT_I;
        end
      end
      GRANT_I, GRANT_D: begin
        // Only beats/responses matching the granted direction advance the transaction.
        if (rd_beat) begin
          if (beat_cnt == LAST_BEAT) begin
            beat_cnt_nxt = '0;
            state_nxt    = IDLE;
          end else begin
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end else if (wr_resp) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    addr_mux  = '0;
    we_mux    = 1'b0;
    wdata_mux = '0;
    wmask_mux = '0;
    grant_vld = 1'b0;
    case (state)
      GRANT_I: begin
        addr_mux  = i_mem.addr;
        we_mux    = i_mem.we;
        wdata_mux = i_mem.wdata;
        wmask_mux = i_mem.wmask;
        grant_vld = 1'b1;
      end
      GRANT_D: begin
        addr_mux  = d_mem.addr;
        we_mux    = d_mem.we;
        wdata_mux = d_mem.wdata;
        wmask_mux = d_mem.wmask;
        grant_vld = 1'b1;
      end
      default: ;
    endcase
    rd_beat = grant_vld & ~we_mux & m.rdata_valid;
    wr_resp = grant_vld &  we_mux & m.write_respone;
  end

  assign m.addr  = addr_mux;
  assign m.ce    = grant_vld;
  assign m.we    = we_mux;
  assign m.wdata = wdata_mux;
  assign m.wmask = wmask_mux;
  assign busy    = grant_vld;

  assign i_mem.rdata         = m.rdata;
  assign d_mem.rdata         = m.rdata;
  assign i_mem.rdata_valid   = rd_beat & (state == GRANT_I);
  assign d_mem.rdata_valid   = rd_beat & (state == GRANT_D);
  assign i_mem.write_respone = wr_resp & (state == GRANT_I);
  assign d_mem.write_respone = wr_resp & (state == GRANT_D);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: per-cycle vector table for writes/spurious responses, hand sequences for bursts and reset.
module tb_cache_mem_arbiter;
  localparam int BW = 32;
  localparam int DW = 32;
  localparam int BL = 16;

  localparam logic [31:0] I_ADDR = 32'h0000_1000;
  localparam logic [31:0] D_ADDR = 32'h0000_0040;
  localparam logic [31:0] I_WD   = 32'h1111_2222;
  localparam logic [3:0]  I_WM   = 4'hF;
  localparam logic [31:0] D_WD   = 32'hDEAD_BEEF;
  localparam logic [3:0]  D_WM   = 4'b0011;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  cache_mem_arbiter_if #(.BUS_WIDTH(BW), .DATA_WIDTH(DW)) i_if ();
  cache_mem_arbiter_if #(.BUS_WIDTH(BW), .DATA_WIDTH(DW)) d_if ();
  cache_mem_arbiter_if #(.BUS_WIDTH(BW), .DATA_WIDTH(DW)) m_if ();

  cache_mem_arbiter #(.BUS_WIDTH(BW), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk   (clk),
    .reset (reset),
    .i_mem (i_if),
    .d_mem (d_if),
    .m     (m_if),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // g: 0 = no grant, 1 = ICache, 2 = DCache
  typedef struct packed {
    logic       rst;
    logic       ice, iwe, dce, dwe, vld, wr;
    logic [1:0] g;
    logic       iv, dv, ir, dr;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    i_if.ce = 1'b0; d_if.ce = 1'b0;
    m_if.rdata_valid = 1'b0; m_if.write_respone = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic burst(input int tgt, input logic [31:0] base, input int n,
                       input bit complete, input bit drop_i, input bit drop_d);
    for (int b = 0; b < n; b++) begin
      @(negedge clk);
      m_if.write_respone = 1'b0;
      m_if.rdata_valid   = 1'b1;
      m_if.rdata         = base + b;
      #1;
      chk("beat_m_ce",   m_if.ce, 32'd1);
      chk("beat_i_vld",  i_if.rdata_valid, (tgt == 1) ? 32'd1 : 32'd0);
      chk("beat_d_vld",  d_if.rdata_valid, (tgt == 2) ? 32'd1 : 32'd0);
      chk("beat_rdata",  (tgt == 1) ? i_if.rdata : d_if.rdata, base + b);
    end
    if (complete) begin
      @(negedge clk);
      m_if.rdata_valid = 1'b0;
      if (drop_i) i_if.ce = 1'b0;
      if (drop_d) d_if.ce = 1'b0;
      #1;
      chk("done_m_ce", m_if.ce, 32'd0);
      chk("done_busy", busy, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_wm;
    logic        e_ce, e_we;
    int          pri_tgt;

    i_if.ce = 0; i_if.we = 0; i_if.addr = I_ADDR; i_if.wdata = I_WD; i_if.wmask = I_WM;
    d_if.ce = 0; d_if.we = 0; d_if.addr = D_ADDR; d_if.wdata = D_WD; d_if.wmask = D_WM;
    m_if.rdata = 32'h5A5A_5A5A; m_if.rdata_valid = 0; m_if.write_respone = 0;

    //           rst ice iwe dce dwe vld wr  g     iv dv ir dr
    vt[0] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0};
    vt[1] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,2'd0,1'b0,1'b0,1'b0,1'b0};
    vt[2] = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0};
    vt[3] = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,2'd2,1'b0,1'b0,1'b0,1'b0};
    vt[4] = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,2'd2,1'b0,1'b0,1'b0,1'b1};
    vt[5] = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0};
    vt[6] = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,2'd1,1'b0,1'b0,1'b0,1'b0};
    vt[7] = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,2'd1,1'b0,1'b0,1'b1,1'b0};
    vt[8] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,2'd0,1'b0,1'b0,1'b0,1'b0};
    vt[9] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0};

    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      reset = vt[k].rst;
      i_if.ce = vt[k].ice; i_if.we = vt[k].iwe;
      d_if.ce = vt[k].dce; d_if.we = vt[k].dwe;
      m_if.rdata_valid = vt[k].vld; m_if.write_respone = vt[k].wr;
      #1;
      e_ce = (vt[k].g != 2'd0);
      e_addr = (vt[k].g == 2'd1) ? I_ADDR : (vt[k].g == 2'd2) ? D_ADDR : 32'd0;
      e_wd   = (vt[k].g == 2'd1) ? I_WD   : (vt[k].g == 2'd2) ? D_WD   : 32'd0;
      e_wm   = (vt[k].g == 2'd1) ? I_WM   : (vt[k].g == 2'd2) ? D_WM   : 4'd0;
      e_we   = (vt[k].g == 2'd1) ? vt[k].iwe : (vt[k].g == 2'd2) ? vt[k].dwe : 1'b0;
      chk($sformatf("v%0d_m_ce", k),    m_if.ce, e_ce);
      chk($sformatf("v%0d_busy", k),    busy, e_ce);
      chk($sformatf("v%0d_m_addr", k),  m_if.addr, e_addr);
      chk($sformatf("v%0d_m_we", k),    m_if.we, e_we);
      chk($sformatf("v%0d_m_wdata", k), m_if.wdata, e_wd);
      chk($sformatf("v%0d_m_wmask", k), m_if.wmask, e_wm);
      chk($sformatf("v%0d_i_vld", k),   i_if.rdata_valid, vt[k].iv);
      chk($sformatf("v%0d_d_vld", k),   d_if.rdata_valid, vt[k].dv);
      chk($sformatf("v%0d_i_wresp", k), i_if.write_respone, vt[k].ir);
      chk($sformatf("v%0d_d_wresp", k), d_if.write_respone, vt[k].dr);
    end

    // ICache-only refill, data 0..15
    @(negedge clk);
    i_if.addr = 32'h0000_1000; i_if.we = 1'b0; i_if.ce = 1'b1;
    #1 chk("icache_latency_m_ce", m_if.ce, 32'd0);
    @(negedge clk);
    #1;
    chk("icache_grant_m_ce", m_if.ce, 32'd1);
    chk("icache_grant_addr", m_if.addr, 32'h0000_1000);
    chk("icache_grant_we", m_if.we, 32'd0);
    burst(1, 32'd0, 16, 1'b1, 1'b1, 1'b0);

    // Spurious responses in IDLE and in a read grant, then deassert mid-refill
    @(negedge clk);
    m_if.rdata_valid = 1'b1; m_if.write_respone = 1'b1;
    #1;
    chk("idle_spur_i_vld", i_if.rdata_valid, 32'd0);
    chk("idle_spur_d_vld", d_if.rdata_valid, 32'd0);
    chk("idle_spur_i_wr",  i_if.write_respone, 32'd0);
    chk("idle_spur_d_wr",  d_if.write_respone, 32'd0);
    @(negedge clk);
    m_if.rdata_valid = 1'b0; m_if.write_respone = 1'b0;
    d_if.addr = 32'h0000_0080; d_if.we = 1'b0; d_if.ce = 1'b1;
    @(negedge clk);
    m_if.write_respone = 1'b1;
    #1;
    chk("dread_grant_addr", m_if.addr, 32'h0000_0080);
    chk("dread_spur_d_wr", d_if.write_respone, 32'd0);
    chk("dread_spur_i_wr", i_if.write_respone, 32'd0);
    burst(2, 32'h500, 4, 1'b0, 1'b0, 1'b0);
    d_if.ce = 1'b0;
    burst(2, 32'h504, 12, 1'b1, 1'b0, 1'b0);

    // Simultaneous requests after reset: D, then I, then D again
    do_reset();
    @(negedge clk);
    i_if.addr = 32'h0000_1000; i_if.we = 1'b0; i_if.ce = 1'b1;
    d_if.addr = 32'h0000_0080; d_if.we = 1'b0; d_if.ce = 1'b1;
    #1 chk("tie1_latency_m_ce", m_if.ce, 32'd0);
    @(negedge clk);
    #1 chk("tie1_addr_d", m_if.addr, 32'h0000_0080);
    burst(2, 32'h600, 16, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    chk("after_d_m_ce", m_if.ce, 32'd1);
    chk("after_d_addr_i", m_if.addr, 32'h0000_1000);
    burst(1, 32'h700, 16, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    i_if.ce = 1'b1; d_if.ce = 1'b1;
    #1 chk("tie3_latency_m_ce", m_if.ce, 32'd0);
    @(negedge clk);
    #1 chk("tie3_addr_d", m_if.addr, 32'h0000_0080);
    burst(2, 32'h800, 16, 1'b1, 1'b0, 1'b0);
`ifdef ARB_DCACHE_PRIORITY_EN
    pri_tgt = 2;
`else
    pri_tgt = 1;
`endif
    @(negedge clk);
    #1 chk("tie4_addr", m_if.addr, (pri_tgt == 2) ? 32'h0000_0080 : 32'h0000_1000);
    burst(pri_tgt, 32'h900, 16, 1'b1, 1'b1, 1'b1);

    // Reset at beat 7 of an ICache refill, then a full refill
    do_reset();
    @(negedge clk);
    i_if.addr = 32'h0000_3000; i_if.we = 1'b0; i_if.ce = 1'b1;
    @(negedge clk);
    #1 chk("rst_seq_grant", m_if.ce, 32'd1);
    burst(1, 32'h100, 7, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1; m_if.rdata_valid = 1'b1; m_if.rdata = 32'h107;
    #1 chk("rst_beat7_i_vld", i_if.rdata_valid, 32'd1);
    @(negedge clk);
    reset = 1'b0; m_if.rdata_valid = 1'b0;
    #1;
    chk("rst_m_ce", m_if.ce, 32'd0);
    chk("rst_busy", busy, 32'd0);
    @(negedge clk);
    #1;
    chk("rst_regrant_m_ce", m_if.ce, 32'd1);
    chk("rst_regrant_addr", m_if.addr, 32'h0000_3000);
    burst(1, 32'h200, 16, 1'b1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
